// File: rtl/mem_io_unit_if.sv
// Bus bundle for mem_io_unit: CPU word access, RAM preload port and the
// outgoing TX stream. The unit takes the slave side; the driver of the
// CPU/preload signals and consumer of the stream takes the master side.
interface mem_io_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [31:0]       address;
  logic [31:0]       datao;
  logic              rw;
  logic [31:0]       data;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  address, datao, rw, load_en, load_addr, load_data, out_ready,
    output data, out_data, out_valid
  );

  modport master (
    output address, datao, rw, load_en, load_addr, load_data, out_ready,
    input  data, out_data, out_valid
  );
endinterface

// File: rtl/mem_io_unit.sv
// Word-addressed RAM plus a small memory-mapped I/O window holding a TX
// register that feeds an output FIFO and a STATUS register reporting
// FIFO occupancy and a sticky overflow flag.
module mem_io_unit #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FFF0
) (
  input  logic    clock,
  input  logic    reset,
  mem_io_if.slave bus
);

  localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned RAM_WORDS   = 1 << ADDR_W;
  localparam logic [3:0]  DEPTH_C     = 4'(FIFO_DEPTH);
  localparam logic [31:0] STATUS_ADDR = IO_BASE + 32'd1;

  // RAM is deliberately outside the reset domain so boot preloads survive.
  logic [31:0]      ram_q [RAM_WORDS];

  logic [31:0]      data_q,     data_d;
  logic [31:0]      fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [3:0]       count_q,    count_d;
  logic             overflow_q, overflow_d;

  logic [ADDR_W-1:0] ram_idx_s;
  logic              is_io_s;
  logic              cpu_wr_s;
  logic              ram_wr_s;
  logic              tx_req_s;
  logic              status_rd_s;
  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              ovf_event_s;
  logic [31:0]       status_word_s;

  // Address decode, FIFO handshake and next-state computation.
  always_comb begin
    ram_idx_s     = bus.address[ADDR_W-1:0];
    is_io_s       = (bus.address >= IO_BASE);
    // A preload strobe steals the cycle from any CPU write.
    cpu_wr_s      = !bus.rw && !bus.load_en;
    ram_wr_s      = cpu_wr_s && !is_io_s;
    tx_req_s      = cpu_wr_s && (bus.address == IO_BASE);
    status_rd_s   = bus.rw && (bus.address == STATUS_ADDR);
    empty_s       = (count_q == 4'd0);
    full_s        = (count_q == DEPTH_C);
    pop_s         = !empty_s && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_s        = tx_req_s && (!full_s || pop_s);
    ovf_event_s   = tx_req_s && full_s && !pop_s;
    status_word_s = {25'd0, overflow_q, full_s, empty_s, count_q};

    data_d = data_q;
    if (bus.rw) begin
      if (!is_io_s) begin
        data_d = ram_q[ram_idx_s];
      end else if (status_rd_s) begin
        data_d = status_word_s;
      end else begin
        data_d = 32'd0;
      end
    end else begin
      data_d = data_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase

    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    // A fresh overflow wins over the clear-on-read of STATUS.
    if (ovf_event_s) begin
      overflow_d = 1'b1;
    end else if (status_rd_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Read data, FIFO storage, pointers, count and overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q     <= 32'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 32'd0;
      end
    end else begin
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push_s) begin
        fifo_q[wr_ptr_q] <= bus.datao;
      end
    end
  end

  // RAM write port: preload has priority, nothing is written while in reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (bus.load_en) begin
        ram_q[bus.load_addr] <= bus.load_data;
      end else if (ram_wr_s) begin
        ram_q[ram_idx_s] <= bus.datao;
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.out_valid = (count_q != 4'd0);
  assign bus.out_data  = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed bench for mem_io_unit: RAM preload/read/write/alias, STATUS and
// overflow behaviour, FIFO ordering with simultaneous push/pop, and reset.
module tb_mem_io_unit;

  localparam logic [31:0] IO_BASE = 32'hFFFF_FFF0;
  localparam logic [31:0] STATUS  = 32'hFFFF_FFF1;
  localparam logic [31:0] IO_NONE = 32'hFFFF_FFF2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mem_io_if #(.ADDR_W(8)) bus ();

  mem_io_unit #(
    .ADDR_W(8),
    .FIFO_DEPTH(4),
    .IO_BASE(IO_BASE)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rw      = 1'b1;
    bus.address = IO_NONE;
    bus.datao   = 32'd0;
    bus.load_en = 1'b0;
  endtask

  task automatic cpu_rd(input logic [31:0] a);
    bus.rw = 1'b1; bus.address = a; bus.load_en = 1'b0;
    step();
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    bus.rw = 1'b0; bus.address = a; bus.datao = d; bus.load_en = 1'b0;
    step();
  endtask

  initial begin
    idle();
    bus.load_addr = 8'd0;
    bus.load_data = 32'd0;
    bus.out_ready = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_data",  bus.data, 32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_odata", bus.out_data, 32'd0);
    step();
    step();
    rst = 1'b0;

    // Preload RAM[3] while a TX write is attempted: the TX write is dropped.
    bus.load_en = 1'b1; bus.load_addr = 8'd3; bus.load_data = 32'h0000_00A7;
    bus.rw = 1'b0; bus.address = IO_BASE; bus.datao = 32'h0000_0055;
    step();
    bus.load_en = 1'b0;
    check("preload_tx_dropped", {31'd0, bus.out_valid}, 32'd0);
    cpu_rd(32'd3);
    check("preload_read", bus.data, 32'h0000_00A7);

    // Write through an aliased address; data holds during the write.
    cpu_wr(32'h0000_0105, 32'hDEAD_BEEF);
    check("write_holds_data", bus.data, 32'h0000_00A7);
    cpu_rd(32'd5);
    check("alias_read", bus.data, 32'hDEAD_BEEF);
    cpu_wr(32'd7, 32'h1234_5678);
    cpu_rd(32'h0000_0F07);
    check("back_to_back", bus.data, 32'h1234_5678);

    // Idle I/O reads.
    cpu_rd(STATUS);
    check("status_idle", bus.data, 32'h0000_0010);
    cpu_rd(32'd3);
    cpu_rd(IO_BASE);
    check("tx_reads_zero", bus.data, 32'd0);
    cpu_rd(32'd3);
    cpu_rd(IO_NONE);
    check("unmapped_reads_zero", bus.data, 32'd0);

    // Fill with out_ready low, then overflow with a fifth word.
    cpu_wr(IO_BASE, 32'd1);
    check("push_valid", {31'd0, bus.out_valid}, 32'd1);
    check("push_head", bus.out_data, 32'd1);
    cpu_wr(IO_BASE, 32'd2);
    cpu_wr(IO_BASE, 32'd3);
    cpu_wr(IO_BASE, 32'd4);
    cpu_wr(IO_BASE, 32'd5);
    cpu_rd(STATUS);
    check("status_overflow", bus.data, 32'h0000_0064);
    cpu_rd(STATUS);
    check("status_cleared", bus.data, 32'h0000_0024);
    check("head_stable", bus.out_data, 32'd1);

    // Drain in order.
    idle();
    bus.out_ready = 1'b1;
    check("drain_1", bus.out_data, 32'd1);
    step();
    check("drain_2", bus.out_data, 32'd2);
    step();
    check("drain_3", bus.out_data, 32'd3);
    step();
    check("drain_4", bus.out_data, 32'd4);
    step();
    check("drain_empty", {31'd0, bus.out_valid}, 32'd0);
    cpu_rd(STATUS);
    check("status_empty", bus.data, 32'h0000_0010);

    // Full FIFO with simultaneous pop accepts a new word without overflow.
    bus.out_ready = 1'b0;
    cpu_wr(IO_BASE, 32'd5);
    cpu_wr(IO_BASE, 32'd6);
    cpu_wr(IO_BASE, 32'd7);
    cpu_wr(IO_BASE, 32'd8);
    bus.out_ready = 1'b1;
    cpu_wr(IO_BASE, 32'd9);
    bus.out_ready = 1'b0;
    cpu_rd(STATUS);
    check("push_pop_full_status", bus.data, 32'h0000_0024);
    idle();
    bus.out_ready = 1'b1;
    check("order_6", bus.out_data, 32'd6);
    step();
    check("order_7", bus.out_data, 32'd7);
    step();
    check("order_8", bus.out_data, 32'd8);
    step();
    check("order_9", bus.out_data, 32'd9);
    step();
    check("order_empty", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-cycle with two words queued and non-zero read data.
    bus.out_ready = 1'b0;
    cpu_wr(IO_BASE, 32'h0000_00AA);
    cpu_wr(IO_BASE, 32'h0000_00BB);
    cpu_rd(32'd3);
    check("pre_reset_data", bus.data, 32'h0000_00A7);
    check("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_reset_data", bus.data, 32'd0);
    check("mid_reset_odata", bus.out_data, 32'd0);
    bus.rw = 1'b0; bus.address = 32'd3; bus.datao = 32'hFFFF_FFFF;
    step();
    rst = 1'b0;
    cpu_rd(32'd3);
    check("ram_survives_reset", bus.data, 32'h0000_00A7);
    cpu_rd(STATUS);
    check("status_after_reset", bus.data, 32'h0000_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
